// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: byte width, TX FIFO depth and the byte type.
// Imported by the TX FIFO and by the UART TX/RX modules.
package uart_tx_fifo_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_TX_FIFO_AW = 4;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_tx_fifo_pkg

// File: rtl/uart_fifo_mem.sv
// FIFO storage: dual-port array with synchronous write and asynchronous read.
// The array is never reset; stale contents are masked by the FIFO's occupancy.
module uart_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : uart_fifo_mem

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: FWFT head on tx_data, sticky
// overflow/underflow flags. Optional almost_full via UART_TX_FIFO_ALMOST_FULL_EN.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_W,
  parameter int ADDR_WIDTH = UART_TX_FIFO_AW
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
  ,
  parameter int AF_MARGIN  = 2
`endif
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_buf_not_empty,
  input  logic                  tx_read_buf,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
`ifdef UART_TX_FIFO_ALMOST_FULL_EN
  output logic                  almost_full,
`endif
  input  logic                  err_clr
);

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  ovf_set;
  logic                  udf_set;

  assign full             = (count == DEPTH);
  assign tx_buf_not_empty = (count != '0);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign pop_ok  = tx_read_buf && tx_buf_not_empty;
  assign push_ok = wr_en && (!full || pop_ok);
  assign ovf_set = wr_en && !push_ok;
  assign udf_set = tx_read_buf && !tx_buf_not_empty;

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + (ADDR_WIDTH+1)'(1);
      2'b01:   count_nxt = count - (ADDR_WIDTH+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      count <= count_nxt;
      // A new error in the same cycle as err_clr keeps the flag set.
      if (ovf_set)      overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (udf_set)      underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end

`ifdef UART_TX_FIFO_ALMOST_FULL_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (count_nxt >= (DEPTH - (ADDR_WIDTH+1)'(AF_MARGIN)));
    end
  end
`endif

  uart_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clock   (clock),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (tx_data)
  );

endmodule : uart_tx_fifo
